// File: rtl/sum_accumulator_if.sv
// Valid/ready bus between the operand adder, the sum accumulator and the result consumer.
// master: environment side (producer of sums, consumer of results); slave: the accumulator.
interface sum_accumulator_if #(
  parameter int unsigned SUM_W = 6,
  parameter int unsigned ACC_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;

  modport master (
    output in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates NUM_SAMPLES adder sums into one total with a sticky overflow flag.
// Define SUM_ACC_SATURATE_EN to clamp the total at 2^ACC_W-1 instead of wrapping.
module sum_accumulator #(
  parameter int unsigned SUM_W       = 6,
  parameter int unsigned ACC_W       = 8,
  parameter int unsigned NUM_SAMPLES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  sum_accumulator_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam int unsigned EXT_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic               out_ovf_q, out_ovf_d;

  logic               accept;
  logic [EXT_W-1:0]   sum_ext;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last;
  logic               carry;
  logic [ACC_W-1:0]   acc_new;
  logic               ovf_new;

  // in_ready depends on state only, so producers see no path from their own valid.
  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_ovf   = out_ovf_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_ovf_d   = out_ovf_q;

    accept  = bus.in_valid && (state_q != HOLD);
    sum_ext = EXT_W'(acc_q) + EXT_W'(bus.in_sum);
    carry   = sum_ext[ACC_W];
    ovf_new = ovf_q | carry;
    cnt_inc = cnt_q + CNT_W'(1);
    last    = (cnt_inc == CNT_W'(NUM_SAMPLES));
`ifdef SUM_ACC_SATURATE_EN
    acc_new = ovf_new ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    acc_new = sum_ext[ACC_W-1:0];
`endif

    if (clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      out_acc_d   = '0;
      out_ovf_d   = 1'b0;
    end else begin
      case (state_q)
        // acc/cnt/ovf are zero in IDLE, so the first sample shares the ACCUM datapath.
        IDLE, ACCUM: begin
          if (accept) begin
            acc_d = acc_new;
            ovf_d = ovf_new;
            cnt_d = cnt_inc;
            if (last) begin
              state_d     = HOLD;
              out_valid_d = 1'b1;
              out_acc_d   = acc_new;
              out_ovf_d   = ovf_new;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
            out_acc_d   = '0;
            out_ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d     = IDLE;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
          out_acc_d   = '0;
          out_ovf_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Randomized and directed bench for sum_accumulator against a batch-level reference model.
// Honours SUM_ACC_SATURATE_EN the same way the design does.
module tb_sum_accumulator;

  localparam int SUM_W = 6;
  localparam int ACC_W = 8;
  localparam int NUM   = 8;
  localparam int MAXV  = (1 << ACC_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  sum_accumulator_if #(.SUM_W(SUM_W), .ACC_W(ACC_W)) bus ();

  sum_accumulator #(.SUM_W(SUM_W), .ACC_W(ACC_W), .NUM_SAMPLES(NUM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: plain integer total of the batch and whether a result is pending.
  bit m_hold;
  int m_cnt;
  int m_total;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int result_of(input int total);
`ifdef SUM_ACC_SATURATE_EN
    return (total > MAXV) ? MAXV : total;
`else
    return total % (MAXV + 1);
`endif
  endfunction

  function automatic int exp_acc();
    return m_hold ? result_of(m_total) : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold <= 1'b0; m_cnt <= 0; m_total <= 0;
    end else if (clear) begin
      m_hold <= 1'b0; m_cnt <= 0; m_total <= 0;
    end else if (m_hold) begin
      if (bus.out_ready) begin
        m_hold <= 1'b0; m_cnt <= 0; m_total <= 0;
      end
    end else if (bus.in_valid) begin
      m_total <= m_total + int'(bus.in_sum);
      m_cnt   <= m_cnt + 1;
      if (m_cnt + 1 == NUM) m_hold <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready",  int'(bus.in_ready),  int'(!m_hold));
      chk("out_valid", int'(bus.out_valid), int'(m_hold));
      chk("out_acc",   int'(bus.out_acc),   exp_acc());
      chk("out_ovf",   int'(bus.out_ovf),   int'(m_hold && (m_total > MAXV)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic batch(input int val, input int n, input bit toggle);
    int  got   = 0;
    int  guard = 0;
    bit  v     = 1'b1;
    bit  take;
    while (got < n && guard < 500) begin
      bus.in_sum   = SUM_W'(val);
      bus.in_valid = toggle ? v : 1'b1;
      v            = !v;
      take         = bus.in_valid && bus.in_ready;
      tick();
      if (take) got++;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (guard >= 500) chk("batch_timeout", got, n);
  endtask

  task automatic wait_valid(input string name, output int acc, output int ovf);
    int guard = 0;
    while (!bus.out_valid && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) chk({name, "_timeout"}, 0, 1);
    acc = int'(bus.out_acc);
    ovf = int'(bus.out_ovf);
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, "_valid"}, int'(bus.out_valid), 0);
    chk({name, "_acc"},   int'(bus.out_acc),   0);
    chk({name, "_ovf"},   int'(bus.out_ovf),   0);
  endtask

  int a, o;

  initial begin
    rst_n        = 1'b0;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sum   = '0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    check_zero_outputs("reset");
    chk("reset_in_ready", int'(bus.in_ready), 1);
    rst_n = 1'b1;
    tick();

    // 1: 8 x 10, consumer always ready
    bus.out_ready = 1'b1;
    batch(10, NUM, 1'b0);
    chk("t1_latency", int'(bus.out_valid), 1);
    wait_valid("t1", a, o);
    chk("t1_acc", a, 80);
    chk("t1_ovf", o, 0);
    tick();
    chk("t1_idle", int'(bus.out_valid), 0);

    // 2: 8 x 63 overflows
    batch(63, NUM, 1'b0);
    wait_valid("t2", a, o);
`ifdef SUM_ACC_SATURATE_EN
    chk("t2_acc", a, 255);
`else
    chk("t2_acc", a, 248);
`endif
    chk("t2_ovf", o, 1);
    tick();

    // 3: result held while consumer stalls; inputs offered but refused
    bus.out_ready = 1'b0;
    batch(5, NUM, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sum   = SUM_W'(33);
      chk("t3_hold_acc",   int'(bus.out_acc),   40);
      chk("t3_hold_valid", int'(bus.out_valid), 1);
      chk("t3_hold_ready", int'(bus.in_ready),  0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("t3_idle", int'(bus.out_valid), 0);

    // 4: clear drops partial total and the sample offered with it
    batch(20, 3, 1'b0);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sum   = SUM_W'(20);
    tick();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    batch(1, NUM, 1'b0);
    wait_valid("t4", a, o);
    chk("t4_acc", a, 8);
    chk("t4_ovf", o, 0);
    tick();

    // 5: async reset mid-batch and while holding
    batch(2, 5, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t5_mid");
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    batch(9, NUM, 1'b0);
    wait_valid("t5_pre", a, o);
    chk("t5_pre_acc", a, 72);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t5_hold");
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    batch(2, NUM, 1'b0);
    wait_valid("t5", a, o);
    chk("t5_acc", a, 16);
    tick();

    // 6: sparse valid, only accepted cycles count
    batch(7, NUM, 1'b1);
    wait_valid("t6", a, o);
    chk("t6_acc", a, 56);
    chk("t6_ovf", o, 0);
    tick();

    // Random traffic with stalls and occasional clears
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_sum    = SUM_W'($urandom_range(0, 63));
      bus.out_ready = ($urandom_range(0, 1) != 0);
      clear         = ($urandom_range(0, 39) == 0);
      tick();
    end
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
